// File: rtl/param_pipeline_core_if.sv
// param_pipeline_core_if: fetch, control and stage-tap bus of param_pipeline_core.
// Perf counter signals exist only when PIPE_PERF_CNT_EN is defined.
interface param_pipeline_core_if #(
   parameter int XLEN = 32,
   parameter int NSTAGES = 4
);
   logic [XLEN-1:0] imem_addr;
   logic [XLEN-1:0] imem_rdata;
   logic stall;
   logic redirect_valid;
   logic [XLEN-1:0] redirect_target;
   logic [XLEN-1:0] pc;
   logic [NSTAGES-1:0] stage_valid;
   logic [NSTAGES*XLEN-1:0] stage_instr;
   logic [NSTAGES*XLEN-1:0] stage_pc;
`ifdef PIPE_PERF_CNT_EN
   logic [31:0] perf_cycles;
   logic [31:0] perf_retired;
   logic [31:0] perf_bubbles;
   modport master (
      input imem_rdata, stall, redirect_valid, redirect_target,
      output imem_addr, pc, stage_valid, stage_instr, stage_pc,
      output perf_cycles, perf_retired, perf_bubbles
   );
   modport slave (
      output imem_rdata, stall, redirect_valid, redirect_target,
      input imem_addr, pc, stage_valid, stage_instr, stage_pc,
      input perf_cycles, perf_retired, perf_bubbles
   );
`else
   modport master (
      input imem_rdata, stall, redirect_valid, redirect_target,
      output imem_addr, pc, stage_valid, stage_instr, stage_pc
   );
   modport slave (
      output imem_rdata, stall, redirect_valid, redirect_target,
      input imem_addr, pc, stage_valid, stage_instr, stage_pc
   );
`endif
endinterface

// File: rtl/param_pipeline_core.sv
// param_pipeline_core: PC generator plus NSTAGES {valid, pc, instr} registers with stall/redirect.
// Optional perf counters (cycles, retired, bubbles) are built when PIPE_PERF_CNT_EN is defined.
module param_pipeline_core #(
   parameter int XLEN = 32,
   parameter int NSTAGES = 4,
   parameter logic [XLEN-1:0] PC_STEP = XLEN'(4),
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter logic [XLEN-1:0] NOP_INSTR = '0,
   parameter int STALL_STAGE = 1,
   parameter int REDIRECT_STAGE = 2
) (
   input logic clk,
   input logic reset,
   param_pipeline_core_if.master bus
);
   logic [XLEN-1:0] pc_q, pc_d;
   logic v_q [NSTAGES];
   logic v_d [NSTAGES];
   logic src_v [NSTAGES];
   logic flush [NSTAGES];
   logic keep [NSTAGES];
   logic [XLEN-1:0] spc_q [NSTAGES];
   logic [XLEN-1:0] spc_d [NSTAGES];
   logic [XLEN-1:0] src_pc [NSTAGES];
   logic [XLEN-1:0] ins_q [NSTAGES];
   logic [XLEN-1:0] ins_d [NSTAGES];
   logic [XLEN-1:0] src_ins [NSTAGES];
   logic redir, hold;
   logic [NSTAGES-1:0] valid_w;
   logic [NSTAGES*XLEN-1:0] instr_w, pcs_w;
   // redirect overrides stall, so hold is only a pure stall
   assign redir = bus.redirect_valid;
   assign hold = bus.stall & ~bus.redirect_valid;
   always_comb begin
      pc_d = redir ? bus.redirect_target : hold ? pc_q : pc_q + PC_STEP;
      src_v[0] = 1'b1;
      src_pc[0] = pc_q;
      src_ins[0] = bus.imem_rdata;
      for (int i = 1; i < NSTAGES; i++) begin
         src_v[i] = v_q[i-1];
         src_pc[i] = spc_q[i-1];
         src_ins[i] = ins_q[i-1];
      end
      for (int i = 0; i < NSTAGES; i++) begin
         flush[i] = redir ? (i <= REDIRECT_STAGE) : (hold && i == STALL_STAGE);
         keep[i] = hold && i < STALL_STAGE;
         v_d[i] = flush[i] ? 1'b0 : keep[i] ? v_q[i] : src_v[i];
         spc_d[i] = flush[i] ? '0 : keep[i] ? spc_q[i] : src_pc[i];
         ins_d[i] = flush[i] ? NOP_INSTR : keep[i] ? ins_q[i] : src_ins[i];
      end
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         pc_q <= RESET_PC;
         for (int i = 0; i < NSTAGES; i++) begin
            v_q[i] <= 1'b0;
            spc_q[i] <= '0;
            ins_q[i] <= NOP_INSTR;
         end
      end else begin
         pc_q <= pc_d;
         v_q <= v_d;
         spc_q <= spc_d;
         ins_q <= ins_d;
      end
   always_comb begin
      valid_w = '0;
      instr_w = '0;
      pcs_w = '0;
      for (int i = 0; i < NSTAGES; i++) begin
         valid_w[i] = v_q[i];
         instr_w[i*XLEN +: XLEN] = ins_q[i];
         pcs_w[i*XLEN +: XLEN] = spc_q[i];
      end
   end
   assign bus.imem_addr = pc_q;
   assign bus.pc = pc_q;
   assign bus.stage_valid = valid_w;
   assign bus.stage_instr = instr_w;
   assign bus.stage_pc = pcs_w;
`ifdef PIPE_PERF_CNT_EN
   logic [31:0] cyc_q, ret_q, bub_q;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         cyc_q <= '0;
         ret_q <= '0;
         bub_q <= '0;
      end else begin
         cyc_q <= cyc_q + 32'd1;
         ret_q <= ret_q + 32'(v_q[NSTAGES-1]);
         bub_q <= bub_q + 32'(bus.stall | bus.redirect_valid);
      end
   assign bus.perf_cycles = cyc_q;
   assign bus.perf_retired = ret_q;
   assign bus.perf_bubbles = bub_q;
`endif
endmodule

// File: tb/tb_param_pipeline_core.sv
// tb_param_pipeline_core: directed plus random stall/redirect traffic checked against a rule-level model.
module tb_param_pipeline_core;
   localparam int N = 4;
   localparam int SS = 1;
   localparam int RS = 2;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int unsigned vectors = 0;
   int unsigned miscompares = 0;
   logic [31:0] m_pc;
   logic m_v [N];
   logic [31:0] m_p [N];
   logic [31:0] m_i [N];
   logic [31:0] m_cyc, m_ret, m_bub;
   logic [31:0] exp6 [N] = '{32'hA000_0014, 32'hA000_0010, 32'hA000_000C, 32'hA000_0008};
   logic [31:0] wrap [3] = '{32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
   always #5 clk = ~clk;
   param_pipeline_core_if #(.XLEN(32), .NSTAGES(N)) bus ();
   param_pipeline_core_if #(.XLEN(32), .NSTAGES(N)) bus2 ();
   assign bus.imem_rdata = bus.imem_addr | 32'hA000_0000;
   assign bus2.imem_rdata = bus2.imem_addr | 32'hA000_0000;
   assign bus2.stall = 1'b0;
   assign bus2.redirect_valid = 1'b0;
   assign bus2.redirect_target = 32'h0;
   param_pipeline_core #(.XLEN(32), .NSTAGES(N), .PC_STEP(32'd4), .RESET_PC(32'h0),
      .NOP_INSTR(32'h0), .STALL_STAGE(SS), .REDIRECT_STAGE(RS))
      dut (.clk(clk), .reset(reset), .bus(bus.master));
   param_pipeline_core #(.XLEN(32), .NSTAGES(N), .PC_STEP(32'd4), .RESET_PC(32'hFFFF_FFF8),
      .NOP_INSTR(32'h0), .STALL_STAGE(SS), .REDIRECT_STAGE(RS))
      dut2 (.clk(clk), .reset(reset), .bus(bus2.master));
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic m_reset();
      m_pc = 32'h0;
      for (int i = 0; i < N; i++) begin
         m_v[i] = 1'b0;
         m_p[i] = 32'h0;
         m_i[i] = 32'h0;
      end
      m_cyc = 0;
      m_ret = 0;
      m_bub = 0;
   endtask
   // Walk from the last stage down so each stage still sees its predecessor's old contents.
   task automatic m_edge(input logic s, input logic r, input logic [31:0] t);
      m_cyc++;
      if (m_v[N-1]) m_ret++;
      if (s || r) m_bub++;
      for (int i = N - 1; i >= 0; i--) begin
         if ((r && i <= RS) || (!r && s && i == SS)) begin
            m_v[i] = 1'b0;
            m_p[i] = 32'h0;
            m_i[i] = 32'h0;
         end else if (!r && s && i < SS) begin
         end else if (i == 0) begin
            m_v[0] = 1'b1;
            m_p[0] = m_pc;
            m_i[0] = m_pc | 32'hA000_0000;
         end else begin
            m_v[i] = m_v[i-1];
            m_p[i] = m_p[i-1];
            m_i[i] = m_i[i-1];
         end
      end
      m_pc = r ? t : s ? m_pc : m_pc + 32'd4;
   endtask
   task automatic check_all();
      chk("pc", bus.pc, m_pc);
      chk("imem_addr", bus.imem_addr, m_pc);
      for (int i = 0; i < N; i++) begin
         chk($sformatf("s%0d_valid", i), 32'(bus.stage_valid[i]), 32'(m_v[i]));
         chk($sformatf("s%0d_pc", i), bus.stage_pc[i*32 +: 32], m_p[i]);
         chk($sformatf("s%0d_instr", i), bus.stage_instr[i*32 +: 32], m_i[i]);
      end
`ifdef PIPE_PERF_CNT_EN
      chk("perf_cycles", bus.perf_cycles, m_cyc);
      chk("perf_retired", bus.perf_retired, m_ret);
      chk("perf_bubbles", bus.perf_bubbles, m_bub);
`endif
   endtask
   task automatic cyc(input logic s, input logic r, input logic [31:0] t);
      bus.stall = s;
      bus.redirect_valid = r;
      bus.redirect_target = t;
      @(posedge clk);
      m_edge(s, r, t);
      @(negedge clk);
      check_all();
   endtask
   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      m_reset();
      #1;
      check_all();
      @(negedge clk);
      reset = 1'b0;
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end
   initial begin
      int guard;
      m_reset();
      bus.stall = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_target = 32'h0;
      #12;
      check_all();
      chk("wrap_reset_pc", bus2.pc, 32'hFFFF_FFF8);
      @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < 6; k++) begin
         cyc(1'b0, 1'b0, 32'h0);
         if (k < 3) chk($sformatf("wrap_pc%0d", k), bus2.pc, wrap[k]);
      end
      chk("plan_pc6", bus.pc, 32'h18);
      for (int i = 0; i < N; i++) begin
         chk($sformatf("plan_s%0d_instr", i), bus.stage_instr[i*32 +: 32], exp6[i]);
         chk($sformatf("plan_s%0d_valid", i), 32'(bus.stage_valid[i]), 32'd1);
      end
      do_reset();
      for (int k = 0; k < 4; k++) cyc(1'b0, 1'b0, 32'h0);
      for (int k = 0; k < 2; k++) begin
         cyc(1'b1, 1'b0, 32'h0);
         chk("stall_pc", bus.pc, 32'h10);
         chk("stall_s0_instr", bus.stage_instr[31:0], 32'hA000_000C);
         chk("stall_s1_valid", 32'(bus.stage_valid[1]), 32'd0);
         chk("stall_s1_instr", bus.stage_instr[63:32], 32'h0);
      end
      for (int k = 0; k < 3; k++) begin
         cyc(1'b0, 1'b0, 32'h0);
         if (k < 2) chk("bubble_s3_valid", 32'(bus.stage_valid[3]), 32'd0);
      end
      chk("resume_s3_pc", bus.stage_pc[127:96], 32'hC);
      guard = 0;
      while (m_pc != 32'h20 && guard < 20) begin
         cyc(1'b0, 1'b0, 32'h0);
         guard++;
      end
      chk("reach_pc20", m_pc, 32'h20);
      cyc(1'b0, 1'b1, 32'h100);
      chk("redir_pc", bus.pc, 32'h100);
      chk("redir_s0_valid", 32'(bus.stage_valid[0]), 32'd0);
      chk("redir_s1_valid", 32'(bus.stage_valid[1]), 32'd0);
      cyc(1'b0, 1'b0, 32'h0);
      chk("redir_s0_v", 32'(bus.stage_valid[0]), 32'd1);
      chk("redir_s0_pc", bus.stage_pc[31:0], 32'h100);
      chk("redir_s0_instr", bus.stage_instr[31:0], 32'hA000_0100);
      cyc(1'b0, 1'b0, 32'h0);
      cyc(1'b1, 1'b1, 32'h40);
      chk("both_pc", bus.pc, 32'h40);
      chk("both_s0_valid", 32'(bus.stage_valid[0]), 32'd0);
      chk("both_s0_pc", bus.stage_pc[31:0], 32'h0);
      cyc(1'b0, 1'b0, 32'h0);
      chk("both_next_s0_pc", bus.stage_pc[31:0], 32'h40);
      for (int k = 0; k < 300; k++)
         cyc($urandom_range(3) == 0, $urandom_range(9) == 0, $urandom & 32'hFFFF_FFFC);
      bus.stall = 1'b1;
      bus.redirect_valid = 1'b0;
      @(posedge clk);
      m_edge(1'b1, 1'b0, 32'h0);
      #2;
      reset = 1'b1;
      m_reset();
      #1;
      check_all();
      @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < 10; k++) cyc(1'b0, 1'b0, 32'h0);
`ifdef PIPE_PERF_CNT_EN
      chk("plan_perf_cycles", bus.perf_cycles, 32'd10);
      chk("plan_perf_retired", bus.perf_retired, 32'(10 - N));
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
